simple_pipe_fetch: RTL and testbench
====================================

Name: simple_pipe_fetch

Overview:
- Instruction fetch stage directly upstream of the 4-register add/sub/and forwarding pipeline; drives that pipeline's 8-bit `inst` input.
- Issues in-order requests to an instruction memory with variable latency and buffers the responses in a small FIFO.
- Presents exactly one instruction or NOP per cycle.
- Supports PC redirect, which flushes buffered and in-flight instructions, and halt.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- DEPTH, 4, instruction FIFO entries; must be a power of two, ≥2.
- NOP_INST, 8'h00, encoding emitted when no valid instruction is available (op=00).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address (current PC).
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  8  fetched instruction {op,rs1,rs2,rd}.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  ADDR_W  new PC.
- halt  in  1  stop requesting and stop issuing.
- inst  out  8  instruction to the pipeline ID stage.
- inst_valid  out  1  inst holds a fetched instruction (0 means NOP filler).
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- rsp_err  out  1  sticky: a response arrived with nothing in flight.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values, applied immediately while rst_n=0:
  - pc=0, FIFO empty, outstanding=0, drop=0.
  - inst=NOP_INST, inst_valid=0, rsp_err=0.
  - imem_req_valid=0.
  - Reset mid-transaction abandons all in-flight requests. The memory side is reset on the same rst_n.
- State registers:
  - pc.
  - FIFO storage plus rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH).
  - count.
  - outstanding: requests accepted, response not yet returned, to be kept.
  - drop: requests accepted before a redirect whose responses are to be discarded.
- Request side (combinational):
  - imem_req_valid = !halt && !redirect_valid && (count + outstanding + drop < DEPTH).
  - imem_req_addr = pc.
  - Accept when imem_req_valid && imem_req_ready: pc <= pc+1 (wraps modulo 2^ADDR_W), outstanding += 1.
- Response side, evaluated each cycle in priority order:
  - If drop>0: response is discarded, drop -= 1.
  - Else if outstanding>0: push imem_rsp_data, outstanding -= 1.
  - Else: response ignored, rsp_err <= 1.
- Issue side (inst and inst_valid are registered):
  - At each edge, if !halt && !redirect_valid && count>0 (occupancy before this edge's push): inst <= FIFO head, inst_valid <= 1, pop.
  - Otherwise: inst <= NOP_INST, inst_valid <= 0.
  - No bypass. A response in cycle t appears on inst at the earliest in cycle t+2 (pushed at edge t, popped at edge t+1).
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Overflow cannot occur because of the credit check. A push at count==DEPTH is a design error and must never be reached.
- Redirect (redirect_valid=1 at an edge) overrides everything else:
  - pc <= redirect_pc; FIFO cleared (count=0, pointers reset to 0).
  - inst <= NOP_INST, inst_valid <= 0; no request is issued this cycle.
  - drop <= drop + outstanding − (1 if a response arrives this cycle).
  - outstanding <= 0.
  - Back-to-back redirects accumulate drop correctly. The first request to redirect_pc may issue the cycle after redirect deasserts.
- Halt:
  - Freezes issue (NOP out) and new requests.
  - In-flight responses are still accepted or dropped, so the FIFO may fill up to DEPTH.
  - Releasing halt resumes issuing from the FIFO head next edge.
- Redirect with halt=1: flush and PC load still occur.

Test Plan:
- Reset, imem_req_ready=1, memory returns mem[a]=a+8'h40 after 1 cycle, no halt -> first req addr 0x00; inst_valid rises 2 cycles after the first response; inst stream 0x40,0x41,0x42… on consecutive cycles; pc wraps 0xFF -> 0x00.
- halt=1 with memory responding -> requests stop after count+outstanding reaches 4, fifo_count=4, inst=0x00, inst_valid=0; release halt -> 4 buffered instructions issue on 4 consecutive cycles in order.
- 3 requests outstanding (3-cycle memory latency), then redirect_pc=0x80 -> next 3 responses discarded, fifo_count=0, first issued instruction is mem[0x80].
- redirect in the same cycle a response arrives with outstanding=2 -> drop=1, exactly one later response dropped.
- imem_req_ready toggling 1,0,1,0 -> addresses issue strictly in order with pc held while ready=0; no duplicate or skipped instruction at the output.
- Spurious imem_rsp_valid with nothing in flight -> rsp_err=1 sticky, FIFO unchanged; rst_n pulsed low mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/simple_pipe_fetch.sv
// rtl/simple_pipe_fetch.sv - instruction fetch stage with credit-checked FIFO, redirect flush and halt
module simple_pipe_fetch #(
    parameter int         ADDR_W   = 8,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] NOP_INST = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [7:0]               imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic [7:0]               inst,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     rsp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop;
    logic [7:0]        r_inst;
    logic              r_inst_valid;
    logic              r_rsp_err;

    logic [SW-1:0]     w_credit_sum;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_rsp_drop;
    logic              w_rsp_keep;
    logic              w_rsp_spur;
    logic              w_rsp_used;
    logic              w_push;
    logic              w_pop;

    // Credit check counts buffered, in-flight kept and in-flight discarded entries
    always_comb begin
        w_credit_sum = SW'(r_count) + SW'(r_outstanding) + SW'(r_drop);
        w_req_valid  = rst_n && !halt && !redirect_valid && (w_credit_sum < SW'(DEPTH));
        w_accept     = w_req_valid && imem_req_ready;
        w_rsp_drop   = imem_rsp_valid && (r_drop != '0);
        w_rsp_keep   = imem_rsp_valid && (r_drop == '0) && (r_outstanding != '0);
        w_rsp_spur   = imem_rsp_valid && (r_drop == '0) && (r_outstanding == '0);
        w_rsp_used   = w_rsp_drop || w_rsp_keep;
        w_push       = w_rsp_keep && !redirect_valid;
        w_pop        = !halt && !redirect_valid && (r_count != '0);
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst           = r_inst;
    assign inst_valid     = r_inst_valid;
    assign fifo_count     = r_count;
    assign rsp_err        = r_rsp_err;

    // Program counter: redirect loads, accepted request advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_accept) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // FIFO storage written at the tail on every kept response
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= imem_rsp_data;
        end
    end

    // FIFO pointers and occupancy; redirect empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // In-flight bookkeeping: redirect converts all kept requests into discards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            r_outstanding <= '0;
            r_drop        <= r_drop + r_outstanding - CW'(w_rsp_used);
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_keep);
            r_drop        <= r_drop - CW'(w_rsp_drop);
        end
    end

    // Issue register: FIFO head when allowed, otherwise NOP filler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end else if (w_pop) begin
            r_inst       <= r_mem[r_rd_ptr];
            r_inst_valid <= 1'b1;
        end else begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
        end
    end

    // Sticky flag for a response that no request accounts for
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_rsp_spur) begin
            r_rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_simple_pipe_fetch.sv
// tb/tb_simple_pipe_fetch.sv - scoreboard bench for simple_pipe_fetch with random memory latency
module tb_simple_pipe_fetch;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [7:0]        imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic [7:0]        inst;
    logic              inst_valid;
    logic [2:0]        fifo_count;
    logic              rsp_err;

    simple_pipe_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_INST(8'h00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .fifo_count     (fifo_count),
        .rsp_err        (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mem_addr_q[$];
    int         mem_due_q[$];
    logic [7:0] model_pc;
    int         cyc            = 0;
    int         lat_lo         = 1;
    int         lat_hi         = 1;
    logic       spurious       = 1'b0;
    int         valid_cnt      = 0;
    int         first_inst_cyc = -1;
    int         first_rsp_cyc  = -1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every valid instruction must be the next one the model expects
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst_valid) begin
                valid_cnt++;
                if (first_inst_cyc < 0) first_inst_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL inst_unexpected actual=%0h required=none", inst);
                end else begin
                    chk("inst_order", int'(inst), int'(exp_q.pop_front()));
                end
            end else begin
                chk("nop_filler", int'(inst), 0);
            end
        end
    end

    // One clock of stimulus plus the memory model and reference-model update
    task automatic step(input logic h, input logic rd, input logic [7:0] rpc, input logic rdy);
        logic rv;
        logic acc;
        @(negedge clk);
        halt           = h;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        rv = spurious || (mem_due_q.size() > 0 && mem_due_q[0] <= cyc);
        imem_rsp_valid = rv;
        if (rv && !spurious) imem_rsp_data = mem_addr_q[0] + 8'h40;
        else                 imem_rsp_data = 8'($urandom);
        #1;
        if (rv && !spurious && first_rsp_cyc < 0) first_rsp_cyc = cyc;
        if (h || rd) chk("req_blocked", int'(imem_req_valid), 0);
        acc = imem_req_valid && rdy;
        if (acc) chk("req_addr", int'(imem_req_addr), int'(model_pc));
        checks++;
        if (int'(fifo_count) > DEPTH) begin
            failures++;
            $display("FAIL fifo_bound actual=%0d required<=%0d", fifo_count, DEPTH);
        end
        @(posedge clk);
        cyc++;
        if (rv && !spurious) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (rd) begin
            exp_q.delete();
            model_pc = rpc;
        end else if (acc) begin
            mem_addr_q.push_back(model_pc);
            mem_due_q.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)) - 1);
            exp_q.push_back(model_pc + 8'h40);
            model_pc = model_pc + 8'd1;
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_inst", int'(inst), 0);
        chk("rst_inst_valid", int'(inst_valid), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_req_valid", int'(imem_req_valid), 0);
        chk("rst_req_addr", int'(imem_req_addr), 0);
    endtask

    initial begin
        int v0;
        int fc0;
        rst_n          = 1'b0;
        halt           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        model_pc       = '0;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Phase A: single-cycle memory, continuous stream across the pc wrap
        lat_lo = 1; lat_hi = 1;
        repeat (300) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rsp_to_inst_latency", first_inst_cyc - first_rsp_cyc, 2);
        chk("stream_continuous", valid_cnt, cyc - first_inst_cyc);
        repeat (6) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Phase B: fill the FIFO under halt, then release
        lat_lo = 8; lat_hi = 8;
        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (12) step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("halt_fifo_full", int'(fifo_count), DEPTH);
        chk("halt_inst_valid", int'(inst_valid), 0);
        v0 = valid_cnt;
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("halt_release_burst", valid_cnt - v0, 4);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("halt_release_no_extra", valid_cnt - v0, 4);

        // Phase C: spurious response with nothing in flight
        fc0 = int'(fifo_count);
        spurious = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        spurious = 1'b0;
        #1;
        chk("spurious_rsp_err", int'(rsp_err), 1);
        chk("spurious_fifo_unchanged", int'(fifo_count), fc0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rsp_err_sticky", int'(rsp_err), 1);

        // Phase D: three in flight, redirect coinciding with a response
        lat_lo = 3; lat_hi = 3;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h80, 1'b1);
        #1;
        chk("redirect_fifo_cleared", int'(fifo_count), 0);
        v0 = valid_cnt;
        repeat (20) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("redirect_resumes", int'(valid_cnt > v0), 1);

        // Asynchronous reset mid-stream
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        model_pc = '0;
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random phase: variable latency, ready toggling, halt and redirect
        lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99, 0) < 10,
                 $urandom_range(99, 0) < 5,
                 8'($urandom),
                 $urandom_range(99, 0) < 70);
        end
        chk("no_spurious_err", int'(rsp_err), 0);

        // Drain: everything the model still expects must come out
        for (int i = 0; i < 100 && (exp_q.size() != 0 || mem_due_q.size() != 0); i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
